// File: rtl/dtc_feature_feeder.sv
// -----------------------------------------------------------------------------
// dtc_feature_feeder
//
// Streaming front end for a combinational decision-tree classifier. Narrow
// feature beats (LSB beat first) are assembled into a full vector. The vector
// is driven onto feat_o for one EVAL cycle. At the end of that cycle the
// classifier's answer (class_i) is registered together with the vector and
// presented on a valid/ready result port. Framing errors and accepted results
// are counted.
//
// Ports
//   clk, rst_n            sole clock (rising edge), async active-low reset
//   s_valid/s_ready       input beat handshake
//   s_data [BEAT_W]       feature beat, LSB beat first
//   s_last                final beat of a vector
//   feat_o [N_FEAT]       assembled vector to the external classifier
//   class_i [CLS_W]       classifier result (combinational in feat_o)
//   m_valid/m_ready       result handshake
//   m_class [CLS_W]       registered class code
//   m_feat [N_FEAT]       vector that produced m_class
//   frame_err             one-cycle pulse after a mis-framed vector
//   err_cnt [8]           framing error count, saturating at 255
//   vec_cnt [CNT_W]       results accepted downstream, wrapping
// -----------------------------------------------------------------------------
module dtc_feature_feeder #(
  parameter int N_FEAT = 12,
  parameter int BEAT_W = 4,
  parameter int CLS_W  = 3,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [BEAT_W-1:0] s_data,
  input  logic              s_last,
  output logic [N_FEAT-1:0] feat_o,
  input  logic [CLS_W-1:0]  class_i,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [CLS_W-1:0]  m_class,
  output logic [N_FEAT-1:0] m_feat,
  output logic              frame_err,
  output logic [7:0]        err_cnt,
  output logic [CNT_W-1:0]  vec_cnt
);

  localparam int BEATS  = N_FEAT / BEAT_W;
  localparam int BCNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BCNT_W-1:0] LAST_IDX = BCNT_W'(BEATS - 1);

  typedef enum logic {
    COLLECT = 1'b0,
    EVAL    = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
  logic [N_FEAT-1:0]   shadow_q, shadow_d;
  logic [N_FEAT-1:0]   feat_q, feat_d;
  logic                m_valid_q, m_valid_d;
  logic [CLS_W-1:0]    m_class_q, m_class_d;
  logic [N_FEAT-1:0]   m_feat_q, m_feat_d;
  logic                frame_err_q, frame_err_d;
  logic [7:0]          err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0]    vec_cnt_q, vec_cnt_d;

  logic                is_final;
  logic                beat_acc;
  logic [N_FEAT-1:0]   assembled;

  assign is_final = (bcnt_q == LAST_IDX);

  // A final beat may only complete a vector when the result register can take
  // it: either empty or being drained on this very edge. Non-final beats of
  // the next vector keep flowing while a result waits.
  assign s_ready  = rst_n && (state_q == COLLECT) &&
                    !(is_final && m_valid_q && !m_ready);
  assign beat_acc = s_valid && s_ready;

  // NOTE: every variable driven here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    bcnt_d      = bcnt_q;
    shadow_d    = shadow_q;
    feat_d      = feat_q;
    m_valid_d   = m_valid_q;
    m_class_d   = m_class_q;
    m_feat_d    = m_feat_q;
    frame_err_d = 1'b0;
    err_cnt_d   = err_cnt_q;
    vec_cnt_d   = vec_cnt_q;

    // Shadow with the current beat merged in; becomes feat_o on a good final beat.
    assembled = shadow_q;
    assembled[bcnt_q*BEAT_W +: BEAT_W] = s_data;

    // Drain first; an EVAL reload below overrides the clear on the same edge.
    if (m_valid_q && m_ready) begin
      m_valid_d = 1'b0;
      vec_cnt_d = vec_cnt_q + CNT_W'(1);
    end

    unique case (state_q)
      COLLECT: begin
        if (beat_acc) begin
          shadow_d = assembled;
          if (is_final && s_last) begin
            feat_d  = assembled;
            bcnt_d  = '0;
            state_d = EVAL;
          end else if (s_last || is_final) begin
            // Early s_last, or final beat without s_last: drop the frame.
            bcnt_d      = '0;
            frame_err_d = 1'b1;
            if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
          end else begin
            bcnt_d = bcnt_q + BCNT_W'(1);
          end
        end
      end
      EVAL: begin
        // class_i has had this whole cycle to settle on feat_o.
        m_class_d = class_i;
        m_feat_d  = feat_q;
        m_valid_d = 1'b1;
        state_d   = COLLECT;
      end
      default: state_d = COLLECT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  // NOTE: all storage here is a handful of flops, so every register, the
  // shadow included, is reset; a mid-vector reset leaves nothing stale.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= COLLECT;
      bcnt_q      <= '0;
      shadow_q    <= '0;
      feat_q      <= '0;
      m_valid_q   <= 1'b0;
      m_class_q   <= '0;
      m_feat_q    <= '0;
      frame_err_q <= 1'b0;
      err_cnt_q   <= '0;
      vec_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      bcnt_q      <= bcnt_d;
      shadow_q    <= shadow_d;
      feat_q      <= feat_d;
      m_valid_q   <= m_valid_d;
      m_class_q   <= m_class_d;
      m_feat_q    <= m_feat_d;
      frame_err_q <= frame_err_d;
      err_cnt_q   <= err_cnt_d;
      vec_cnt_q   <= vec_cnt_d;
    end
  end

  assign feat_o    = feat_q;
  assign m_valid   = m_valid_q;
  assign m_class   = m_class_q;
  assign m_feat    = m_feat_q;
  assign frame_err = frame_err_q;
  assign err_cnt   = err_cnt_q;
  assign vec_cnt   = vec_cnt_q;

endmodule

// File: tb/tb_dtc_feature_feeder.sv
// -----------------------------------------------------------------------------
// Testbench for dtc_feature_feeder (CNT_W reduced to 4 to reach the wrap).
// A stand-in classifier drives class_i = feat_o[2:0] ^ feat_o[11:9].
// Expected results come from a vector-level model: a vector is the three beats
// concatenated LSB first, and its class is computed from that vector.
// Inputs change 1 time unit after a rising edge; outputs are sampled either
// there or on the falling edge.
// -----------------------------------------------------------------------------
module tb_dtc_feature_feeder;

  localparam int N_FEAT = 12;
  localparam int BEAT_W = 4;
  localparam int CLS_W  = 3;
  localparam int CNT_W  = 4;
  localparam int BEATS  = N_FEAT / BEAT_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic [BEAT_W-1:0] s_data = '0;
  logic              s_last = 1'b0;
  logic [N_FEAT-1:0] feat_o;
  logic [CLS_W-1:0]  class_i;
  logic              m_valid;
  logic              m_ready = 1'b0;
  logic [CLS_W-1:0]  m_class;
  logic [N_FEAT-1:0] m_feat;
  logic              frame_err;
  logic [7:0]        err_cnt;
  logic [CNT_W-1:0]  vec_cnt;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  dtc_feature_feeder #(
    .N_FEAT(N_FEAT), .BEAT_W(BEAT_W), .CLS_W(CLS_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .feat_o(feat_o), .class_i(class_i),
    .m_valid(m_valid), .m_ready(m_ready), .m_class(m_class), .m_feat(m_feat),
    .frame_err(frame_err), .err_cnt(err_cnt), .vec_cnt(vec_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in classifier sitting between feat_o and class_i.
  assign class_i = feat_o[2:0] ^ feat_o[11:9];

  // Reference: class of a whole vector, straight from the classifier rule.
  function automatic logic [2:0] ref_class(input logic [11:0] v);
    return v[2:0] ^ v[11:9];
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic apply_reset();
    s_valid = 1'b0; s_last = 1'b0; s_data = '0; m_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    step();
  endtask

  // Offer one beat; return once it has been accepted (or the wait expired).
  task automatic send_beat(input logic [3:0] d, input logic last);
    int waited;
    waited = 0;
    s_valid = 1'b1; s_data = d; s_last = last;
    @(negedge clk);
    while (!s_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!s_ready) begin
      checks++; errors++;
      $display("FAIL beat_accept_timeout got s_ready=%b want 1 within 200 cycles", s_ready);
    end
    @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic send_vector(input logic [11:0] v);
    for (int i = 0; i < BEATS; i++) send_beat(v[i*BEAT_W +: BEAT_W], i == BEATS - 1);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL rst_s_ready got=%b want=0", s_ready); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rst_m_valid got=%b want=0", m_valid); end
    checks++; if (feat_o !== 12'h000) begin errors++; $display("FAIL rst_feat got=%h want=000", feat_o); end
    checks++; if ({frame_err, err_cnt, vec_cnt} !== 13'h0) begin errors++;
      $display("FAIL rst_counters got fe=%b err=%0d vec=%0d want all 0", frame_err, err_cnt, vec_cnt); end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    step();
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready got=%b want=1", s_ready); end
  endtask

  task automatic test_basic();
    apply_reset();
    m_ready = 1'b1;
    send_beat(4'h3, 1'b0);
    send_beat(4'h1, 1'b0);
    send_beat(4'hA, 1'b1);
    checks++; if (feat_o !== 12'hA13) begin errors++; $display("FAIL basic_feat got=%h want=a13", feat_o); end
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL basic_eval_ready got=%b want=0", s_ready); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got=%b want=0", m_valid); end
    step();
    checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got=%b want=1", m_valid); end
    checks++; if (m_class !== 3'b110) begin errors++; $display("FAIL basic_class got=%b want=110", m_class); end
    checks++; if (m_feat !== 12'hA13) begin errors++; $display("FAIL basic_mfeat got=%h want=a13", m_feat); end
    step();
    checks++; if (vec_cnt !== 4'd1) begin errors++; $display("FAIL basic_vec_cnt got=%0d want=1", vec_cnt); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL basic_drained got=%b want=0", m_valid); end
  endtask

  task automatic test_backpressure();
    logic [11:0] v1, v2;
    v1 = 12'h4B2; v2 = 12'h9E7;
    apply_reset();
    m_ready = 1'b0;
    send_vector(v1);
    send_beat(v2[3:0], 1'b0);
    send_beat(v2[7:4], 1'b0);
    checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL bp_first_valid got=%b want=1", m_valid); end
    s_valid = 1'b1; s_data = v2[11:8]; s_last = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL bp_stall_ready k=%0d got=%b want=0", k, s_ready); end
      checks++; if ({m_valid, m_feat, m_class} !== {1'b1, v1, ref_class(v1)}) begin errors++;
        $display("FAIL bp_hold k=%0d got v=%b f=%h c=%0d want v=1 f=%h c=%0d", k, m_valid, m_feat, m_class, v1, ref_class(v1)); end
    end
    step();
    m_ready = 1'b1;
    @(negedge clk);
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got=%b want=1", s_ready); end
    step();
    s_valid = 1'b0; s_last = 1'b0;
    checks++; if (feat_o !== v2) begin errors++; $display("FAIL bp_feat2 got=%h want=%h", feat_o, v2); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL bp_cleared got=%b want=0", m_valid); end
    checks++; if (vec_cnt !== 4'd1) begin errors++; $display("FAIL bp_vec1 got=%0d want=1", vec_cnt); end
    step();
    checks++; if ({m_valid, m_feat, m_class} !== {1'b1, v2, ref_class(v2)}) begin errors++;
      $display("FAIL bp_second got v=%b f=%h c=%0d want v=1 f=%h c=%0d", m_valid, m_feat, m_class, v2, ref_class(v2)); end
    step();
    checks++; if (vec_cnt !== 4'd2) begin errors++; $display("FAIL bp_vec2 got=%0d want=2", vec_cnt); end
  endtask

  task automatic test_framing();
    logic [11:0] v;
    v = 12'h7C5;
    apply_reset();
    m_ready = 1'b1;
    send_beat(4'h2, 1'b0);
    send_beat(4'h6, 1'b1);
    checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL fr_early_pulse got=%b want=1", frame_err); end
    checks++; if (err_cnt !== 8'd1) begin errors++; $display("FAIL fr_early_cnt got=%0d want=1", err_cnt); end
    checks++; if (feat_o !== 12'h000) begin errors++; $display("FAIL fr_feat_unchanged got=%h want=000", feat_o); end
    step();
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL fr_pulse_width got=%b want=0", frame_err); end
    for (int i = 0; i < BEATS; i++) send_beat(4'(i + 8), 1'b0);
    checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL fr_missing_pulse got=%b want=1", frame_err); end
    checks++; if (err_cnt !== 8'd2) begin errors++; $display("FAIL fr_missing_cnt got=%0d want=2", err_cnt); end
    repeat (3) step();
    checks++; if ({m_valid, vec_cnt} !== 5'b0) begin errors++;
      $display("FAIL fr_no_result got v=%b vec=%0d want 0/0", m_valid, vec_cnt); end
    send_vector(v);
    checks++; if (feat_o !== v) begin errors++; $display("FAIL fr_good_feat got=%h want=%h", feat_o, v); end
    step();
    checks++; if ({m_valid, m_feat, m_class} !== {1'b1, v, ref_class(v)}) begin errors++;
      $display("FAIL fr_good_result got v=%b f=%h c=%0d want v=1 f=%h c=%0d", m_valid, m_feat, m_class, v, ref_class(v)); end
    step();
    checks++; if ({err_cnt, vec_cnt} !== {8'd2, 4'd1}) begin errors++;
      $display("FAIL fr_final_counts got err=%0d vec=%0d want 2/1", err_cnt, vec_cnt); end
  endtask

  task automatic test_saturate_wrap();
    apply_reset();
    for (int i = 0; i < 300; i++) begin
      send_beat(4'($urandom), 1'b1);
      if (i == 254) begin
        checks++; if (err_cnt !== 8'd255) begin errors++; $display("FAIL sat_reach got=%0d want=255", err_cnt); end
      end
    end
    checks++; if (err_cnt !== 8'd255) begin errors++; $display("FAIL sat_hold got=%0d want=255", err_cnt); end
    m_ready = 1'b1;
    for (int i = 0; i < 17; i++) send_vector(12'($urandom));
    repeat (3) step();
    checks++; if (vec_cnt !== 4'd1) begin errors++; $display("FAIL wrap_vec_cnt got=%0d want=1", vec_cnt); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL wrap_idle got=%b want=0", m_valid); end
  endtask

  task automatic test_midreset();
    logic [11:0] v3;
    logic [11:0] seen;
    int n;
    v3 = 12'h1D4;
    apply_reset();
    send_beat(4'h1, 1'b1);
    m_ready = 1'b1;
    send_vector(12'h5A6);
    repeat (2) step();
    m_ready = 1'b0;
    send_vector(12'h3C9);
    step();
    send_beat(4'h7, 1'b0);
    send_beat(4'h8, 1'b0);
    rst_n = 1'b0;
    #2;
    checks++; if ({m_valid, m_class, m_feat, feat_o, frame_err, err_cnt, vec_cnt, s_ready} !== '0) begin errors++;
      $display("FAIL mr_vec_zero got v=%b c=%0d mf=%h f=%h fe=%b err=%0d vec=%0d rdy=%b want all 0",
               m_valid, m_class, m_feat, feat_o, frame_err, err_cnt, vec_cnt, s_ready); end
    @(negedge clk) rst_n = 1'b1;
    step();
    send_vector(12'h2B8);
    rst_n = 1'b0;
    #2;
    checks++; if ({m_valid, m_feat, feat_o, s_ready} !== '0) begin errors++;
      $display("FAIL mr_eval_zero got v=%b mf=%h f=%h rdy=%b want all 0", m_valid, m_feat, feat_o, s_ready); end
    @(negedge clk) rst_n = 1'b1;
    step();
    m_ready = 1'b1;
    send_vector(v3);
    n = 0; seen = '0;
    repeat (8) begin
      @(negedge clk);
      if (m_valid && m_ready) begin n++; seen = m_feat; end
    end
    step();
    checks++; if (n !== 1) begin errors++; $display("FAIL mr_one_result got=%0d want=1", n); end
    checks++; if (seen !== v3) begin errors++; $display("FAIL mr_result_feat got=%h want=%h", seen, v3); end
    checks++; if ({err_cnt, vec_cnt} !== {8'd0, 4'd1}) begin errors++;
      $display("FAIL mr_counts got err=%0d vec=%0d want 0/1", err_cnt, vec_cnt); end
  endtask

  // Random vectors through random backpressure, then peak-rate spacing.
  task automatic test_throughput();
    logic [11:0] exp_q[$];
    int stamps[$];
    int got;
    apply_reset();
    got = 0;
    fork
      begin
        for (int i = 0; i < 50; i++) begin
          logic [11:0] v;
          v = 12'($urandom);
          exp_q.push_back(v);
          send_vector(v);
        end
      end
      begin
        int budget;
        logic [11:0] e;
        budget = 0;
        while (got < 50 && budget < 3000) begin
          @(posedge clk); #1;
          m_ready = 1'($urandom);
          @(negedge clk);
          budget++;
          if (m_valid && m_ready) begin
            got++;
            checks++;
            if (exp_q.size() == 0) begin
              errors++; $display("FAIL tp_extra_result got f=%h want none", m_feat);
            end else begin
              e = exp_q.pop_front();
              if ({m_feat, m_class} !== {e, ref_class(e)}) begin errors++;
                $display("FAIL tp_result got f=%h c=%0d want f=%h c=%0d", m_feat, m_class, e, ref_class(e)); end
            end
          end
        end
        checks++;
        if (got < 50) begin errors++; $display("FAIL tp_timeout got=%0d results want=50", got); end
      end
    join
    step();
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL tp_lost got=%0d pending want=0", exp_q.size()); end

    m_ready = 1'b1;
    got = 0;
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          logic [11:0] v;
          v = 12'($urandom);
          exp_q.push_back(v);
          send_vector(v);
        end
      end
      begin
        int budget;
        logic [11:0] e;
        budget = 0;
        while (got < 10 && budget < 500) begin
          @(negedge clk);
          budget++;
          if (m_valid && m_ready) begin
            got++;
            stamps.push_back(cyc);
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 12'hFFF;
            checks++;
            if ({m_feat, m_class} !== {e, ref_class(e)}) begin errors++;
              $display("FAIL tp_peak_result got f=%h c=%0d want f=%h c=%0d", m_feat, m_class, e, ref_class(e)); end
          end
        end
        checks++;
        if (got < 10) begin errors++; $display("FAIL tp_peak_timeout got=%0d results want=10", got); end
      end
    join
    step();
    for (int i = 1; i < stamps.size(); i++) begin
      checks++;
      if (stamps[i] - stamps[i-1] != BEATS + 1) begin errors++;
        $display("FAIL tp_spacing idx=%0d got=%0d want=%0d", i, stamps[i] - stamps[i-1], BEATS + 1); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_framing();
    test_saturate_wrap();
    test_midreset();
    test_throughput();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got no completion want finish before 50000 cycles");
    $fatal(1, "watchdog expired");
  end

endmodule
